// File: rtl/adder_operand_feeder_if.sv
// Operand handshake and interleaved adder bus between the feeder and its neighbours.
// The feeder is the master of the adder bus; the environment uses the slave view.
interface adder_operand_feeder_if #(
    parameter int WIDTH = 12
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] adder_bus;

    modport master (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, adder_bus
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, adder_bus
    );
endinterface

// File: rtl/adder_operand_feeder.sv
// Operand feeder for the 12-bit Brent-Kung adder: FIFO-buffered (A,B) pairs are
// presented one at a time on a registered, bit-interleaved bus.
module adder_operand_feeder_lane (
    input  logic       a,
    input  logic       b,
    output logic [1:0] pair
);
    assign pair = {b, a};
endmodule

module adder_operand_feeder #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    adder_operand_feeder_if.master   bus,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issued_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] bus_q;
    logic [CNT_W-1:0]   cnt;

    logic               push;
    logic               pop;
    logic               bypass;
    logic               wr_en;
    logic               load;
    logic               slot_free;
    logic               fifo_empty;
    logic               handshake;
    pair_t              in_pair;
    pair_t              load_pair;
    logic [2*WIDTH-1:0] load_bus;

    // Ready depends only on held state: a pop in the same cycle never frees a slot early.
    assign bus.in_ready = rst_n & (level < LVL_W'(DEPTH)) & ~flush;

    assign push       = bus.in_valid & bus.in_ready;
    assign slot_free  = ~out_valid_q | bus.out_ready;
    assign fifo_empty = (level == '0);
    assign pop        = slot_free & ~fifo_empty;
    assign bypass     = slot_free & fifo_empty & push;
    assign wr_en      = push & ~bypass;
    assign load       = pop | bypass;
    assign handshake  = out_valid_q & bus.out_ready;

    assign in_pair    = '{a: bus.in_a, b: bus.in_b};
    assign load_pair  = pop ? mem[rd_ptr] : in_pair;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        adder_operand_feeder_lane u_lane (
            .a    (load_pair.a[i]),
            .b    (load_pair.b[i]),
            .pair (load_bus[2*i+1:2*i])
        );
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_pair;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            bus_q       <= '0;
            cnt         <= '0;
        end else begin
            if (handshake) cnt <= cnt + 1'b1;
            // Flush drops queued and live pairs but leaves the bus value in place.
            if (flush) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                level       <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop)   rd_ptr <= rd_ptr + 1'b1;
                level <= level + LVL_W'(wr_en) - LVL_W'(pop);
                if (load) begin
                    out_valid_q <= 1'b1;
                    bus_q       <= load_bus;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.adder_bus = bus_q;
    assign fifo_level    = level;
    assign issued_cnt    = cnt;
endmodule

// File: tb/tb_adder_operand_feeder.sv
// Scoreboard bench: accepted pairs queue their expected bus/sum; a negedge monitor
// checks every out_valid & out_ready handshake against the queue head.
module tb_adder_operand_feeder;
    typedef struct {
        logic [23:0] bus;
        logic [12:0] sum;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  fifo_level;
    logic [15:0] issued_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    adder_operand_feeder_if #(.WIDTH(12)) ifc ();

    adder_operand_feeder #(.WIDTH(12), .DEPTH(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (ifc),
        .fifo_level (fifo_level),
        .issued_cnt (issued_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] ilv(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] r;
        for (int i = 0; i < 12; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic logic [12:0] sum_of(input logic [23:0] v);
        logic [11:0] a;
        logic [11:0] b;
        for (int i = 0; i < 12; i++) begin
            a[i] = v[2*i];
            b[i] = v[2*i+1];
        end
        return 13'(a) + 13'(b);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the pair.
    task automatic send(input logic [11:0] a, input logic [11:0] b);
        int  waited;
        bit  ok;
        exp_t e;
        waited = 0;
        ok = 1'b1;
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        @(negedge clk);
        while (!ifc.in_ready) begin
            waited++;
            if (waited > 20) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end else begin
            e.bus = ilv(a, b);
            e.sum = 13'(a) + 13'(b);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got bus 0x%0h, expected no output", ifc.adder_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bus", 32'(ifc.adder_bus), 32'(e.bus));
                    check("out_sum", 32'(sum_of(ifc.adder_bus)), 32'(e.sum));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b0;
        #23;
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_bus", 32'(ifc.adder_bus), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_cnt", 32'(issued_cnt), 32'd0);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

        // Single pair, free slot: visible the cycle after acceptance.
        send(12'h0FF, 12'h001);
        check("t1_out_valid", 32'(ifc.out_valid), 32'd1);
        check("t1_bus", 32'(ifc.adder_bus), 32'h005557);
        check("t1_sum", 32'(sum_of(ifc.adder_bus)), 32'h100);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        check("t1_drop_valid", 32'(ifc.out_valid), 32'd0);
        check("t1_bus_held", 32'(ifc.adder_bus), 32'h005557);

        // Backpressure: slot plus two FIFO entries, then drain in order.
        send(12'd1, 12'd2);
        send(12'd3, 12'd4);
        send(12'd5, 12'd6);
        check("t2_level_full", 32'(fifo_level), 32'd2);
        check("t2_in_ready", 32'(ifc.in_ready), 32'd0);
        check("t2_out_valid", 32'(ifc.out_valid), 32'd1);
        ifc.out_ready = 1'b1;
        tick();
        check("t2_level_1", 32'(fifo_level), 32'd1);
        tick();
        check("t2_level_0", 32'(fifo_level), 32'd0);
        tick();
        check("t2_drained", 32'(ifc.out_valid), 32'd0);
        ifc.out_ready = 1'b0;

        // Full FIFO with a same-cycle pop: the push is still refused.
        send(12'd7, 12'd8);
        send(12'd9, 12'd10);
        send(12'd11, 12'd12);
        ifc.in_valid  = 1'b1;
        ifc.in_a      = 12'd13;
        ifc.in_b      = 12'd14;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("t3_refused", 32'(ifc.in_ready), 32'd0);
        tick();
        ifc.in_valid = 1'b0;
        check("t3_level", 32'(fifo_level), 32'd1);
        check("t3_ready_back", 32'(ifc.in_ready), 32'd1);
        tick();
        tick();
        check("t3_drained", 32'(ifc.out_valid), 32'd0);
        ifc.out_ready = 1'b0;

        // Flush with a live slot and two queued pairs, handshake completing that cycle.
        send(12'h100, 12'h200);
        send(12'h300, 12'h400);
        send(12'h500, 12'h600);
        flush         = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_a      = 12'hAAA;
        ifc.in_b      = 12'h555;
        @(negedge clk);
        check("t5_flush_in_ready", 32'(ifc.in_ready), 32'd0);
        tick();
        exp_q.delete();
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        check("t5_out_valid", 32'(ifc.out_valid), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);
        check("t5_bus_kept", 32'(ifc.adder_bus), 32'h090000);
        check("t5_cnt", 32'(issued_cnt), 32'd8);
        send(12'h123, 12'h456);
        check("t5_next_valid", 32'(ifc.out_valid), 32'd1);
        check("t5_next_bus", 32'(ifc.adder_bus), 32'(ilv(12'h123, 12'h456)));
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;

        // Asynchronous reset in the middle of a held stream.
        send(12'd21, 12'd22);
        send(12'd23, 12'd24);
        send(12'd25, 12'd26);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_out_valid", 32'(ifc.out_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_cnt", 32'(issued_cnt), 32'd0);
        check("t6_in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        check("t6_in_ready_held", 32'(ifc.in_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("t6_in_ready_rel", 32'(ifc.in_ready), 32'd1);
        tick();

        // Long stream through the bypass path; the counter wraps to 1.
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            send(12'(i), 12'(i * 5 + 3));
        end
        tick();
        tick();
        ifc.out_ready = 1'b0;
        check("t4_cnt_wrap", 32'(issued_cnt), 32'd1);
        check("t4_idle", 32'(ifc.out_valid), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
